seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 6, giving the number of scanned digit slots, with select values NUM_DIGITS-1 down to 0.
REQ-003 The block SHALL have port clk  input  1  system clock; all sampling is on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port seg7_sel  input  3  digit select of the observed scan bus, asynchronous to clk.
REQ-006 The block SHALL have port seg7_out  input  7  segment pattern, ordered abcdefg with a in bit 6; a lit segment is 1.
REQ-007 The block SHALL have port dpt_out  input  1  decimal-point bit of the observed scan bus.
REQ-008 The block SHALL have port digits_out  output  24  decoded frame, with the nibble at [4k+3:4k] holding slot k (slot 5 in [23:20]).
REQ-009 The block SHALL have port dps_out  output  6  decimal-point bits of the frame, with bit k holding slot k.
REQ-010 The block SHALL have port frame_valid  output  1  one-cycle pulse when digits_out, dps_out and frame_err update.
REQ-011 The block SHALL have port frame_err  output  1  high when any digit of the last delivered frame was an invalid pattern.
REQ-012 The block SHALL have port seq_err  output  1  one-cycle pulse on a scan-order violation.

Function
REQ-013 The block SHALL synchronise seg7_sel, seg7_out and dpt_out through two flip-flop stages; all later rules apply to the synchronised sample S.
REQ-014 The block SHALL count consecutive cycles in which S equals the previous S, restarting the count on any difference.
REQ-015 The block SHALL capture a sample once when S has been identical for STABLE_CYCLES cycles, and SHALL NOT capture again until S changes.
REQ-016 The block SHALL decode the segment pattern as 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9 (hex patterns).
REQ-017 The block SHALL decode pattern 00 as 4'hE (blank, not an error), and SHALL decode every other pattern as 4'hF and mark the digit invalid.
REQ-018 The block SHALL implement the states SYNC, SCAN and DELIVER.
REQ-019 In SYNC, the block SHALL ignore captures until a capture with sel=NUM_DIGITS-1 occurs; it SHALL then store that slot and move to SCAN with expected sel = NUM_DIGITS-2.
REQ-020 In SCAN, a capture with sel equal to the expected value SHALL store the digit nibble, the dp bit and the invalid flag into that slot, then decrement the expected sel.
REQ-021 In SCAN, once slot 0 has been stored, the block SHALL move to DELIVER.
REQ-022 In SCAN, a capture with sel other than the expected value, or with sel >= NUM_DIGITS, SHALL pulse seq_err for one cycle on the following cycle, discard partial slots and return to SYNC.
REQ-023 A capture identical to the previous capture (same sel, no intervening change) SHALL NOT count as an event.
REQ-024 DELIVER SHALL last one cycle, during which the block SHALL load digits_out, dps_out and frame_err (OR of the slot invalid flags) together, assert frame_valid and go to SCAN with expected sel = NUM_DIGITS-1.
REQ-025 Between frame_valid pulses, digits_out, dps_out and frame_err SHALL hold their values.
REQ-026 The latency from the capture of slot 0 to frame_valid SHALL be exactly 1 cycle.
REQ-027 If sel=NUM_DIGITS-1 arrives while in SYNC, SCAN always restarts from it; a single hold of sel longer than STABLE_CYCLES SHALL NOT produce multiple captures.

Reset
REQ-028 While reset=0, the block SHALL force digits_out=0, dps_out=0, frame_valid=0, frame_err=0, seq_err=0, all slots, the stability count and the synchronisers to 0, and the state to SYNC.
REQ-029 On reset release mid-scan, the block SHALL deliver no frame until a complete scan from NUM_DIGITS-1 down to 0 has been observed.

Structure
REQ-030 Shared package seg7_pkg SHALL hold the ten segment-pattern constants, the BLANK (4'hE) and INVALID (4'hF) codes, and the state typedef.
REQ-031 Pattern decoding SHALL be a combinational sub-module seg7_to_bcd (7-bit pattern in; 4-bit code and invalid flag out); everything else SHALL reside in seg7_scan_decoder.

Verification
REQ-032 The bench SHALL cover: scan sel 5..0 holding 8 cycles each with digits 1,1,1,8,7,3 and dp 1,0,0,1,0,1 -> one frame_valid pulse, digits_out=24'h111873, dps_out=6'b100101, frame_err=0.
REQ-033 The bench SHALL cover: a 2-cycle glitch of seg7_out=7F during the sel=3 hold of digit 1 -> nibble 3 = 1 and no extra capture.
REQ-034 The bench SHALL cover: first stable sel=2, then a full 5..0 scan -> exactly one frame_valid, delivered after sel=0 of the full scan.
REQ-035 The bench SHALL cover: a scan 5,4,2 -> seq_err one-cycle pulse with no frame_valid, and the next full scan delivers normally.
REQ-036 The bench SHALL cover: pattern 55 at sel=3 and 00 at sel=5 -> digits_out[15:12]=F, [23:20]=E, frame_err=1.
REQ-037 The bench SHALL cover: reset=0 asserted after sel=2 is captured -> all outputs 0 immediately, and no frame_valid before the next complete 5..0 scan.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns
// (abcdefg, a in bit 6), special output codes and the frame-tracking states.
package seg7_pkg;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_SCAN,
        ST_DELIVER
    } state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; blank decodes to
// CODE_BLANK, anything unrecognised to CODE_INVALID with invalid set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = CODE_INVALID;
        invalid = 1'b1;
        case (pattern)
            SEG_0:     begin code = 4'd0; invalid = 1'b0; end
            SEG_1:     begin code = 4'd1; invalid = 1'b0; end
            SEG_2:     begin code = 4'd2; invalid = 1'b0; end
            SEG_3:     begin code = 4'd3; invalid = 1'b0; end
            SEG_4:     begin code = 4'd4; invalid = 1'b0; end
            SEG_5:     begin code = 4'd5; invalid = 1'b0; end
            SEG_6:     begin code = 4'd6; invalid = 1'b0; end
            SEG_7:     begin code = 4'd7; invalid = 1'b0; end
            SEG_8:     begin code = 4'd8; invalid = 1'b0; end
            SEG_9:     begin code = 4'd9; invalid = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; invalid = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed seven-segment scan bus, debounces each digit slot and
// assembles complete NUM_DIGITS-1..0 scans into decoded frames.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              seg7_sel,
    input  logic [6:0]              seg7_out,
    input  logic                    dpt_out,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dps_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    seq_err
);

    localparam logic [2:0] TOP_SEL = 3'(NUM_DIGITS - 1);
    localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [10:0] sync1_reg, sync2_reg, prev_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic        same, capture, cap_event;
    logic [2:0]  s_sel;
    logic [6:0]  s_seg;
    logic        s_dp;
    logic [3:0]  dec_code;
    logic        dec_invalid;
    logic [2:0]  last_sel_reg;
    logic        last_valid_reg;

    state_t      state_reg, state_next;
    logic [2:0]  exp_sel_reg, exp_sel_next;
    logic        slot_we, slot_clr, deliver_load, seq_err_next;

    logic [4*NUM_DIGITS-1:0] slot_digits_reg, slot_digits_next;
    logic [NUM_DIGITS-1:0]   slot_dps_reg, slot_dps_next;
    logic [NUM_DIGITS-1:0]   slot_inv_reg, slot_inv_next;

    assign s_sel = sync2_reg[10:8];
    assign s_seg = sync2_reg[7:1];
    assign s_dp  = sync2_reg[0];

    // The run counter saturates so a long hold produces exactly one capture.
    assign same    = (sync2_reg == prev_reg);
    assign capture = same && (cnt_reg == CNT_CAP);
    assign cnt_next = !same ? 8'd1 : ((cnt_reg != CNT_MAX) ? cnt_reg + 8'd1 : cnt_reg);

    // A re-capture of the slot just taken (e.g. after a short glitch) is not new.
    assign cap_event = capture && !(last_valid_reg && (s_sel == last_sel_reg));

    seg7_to_bcd u_dec (
        .pattern (s_seg),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    always_comb begin
        state_next   = state_reg;
        exp_sel_next = exp_sel_reg;
        slot_we      = 1'b0;
        slot_clr     = 1'b0;
        deliver_load = 1'b0;
        seq_err_next = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                if (cap_event && (s_sel == TOP_SEL)) begin
                    slot_we      = 1'b1;
                    exp_sel_next = TOP_SEL - 3'd1;
                    state_next   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cap_event) begin
                    if (s_sel == exp_sel_reg) begin
                        slot_we = 1'b1;
                        if (exp_sel_reg == 3'd0) begin
                            deliver_load = 1'b1;
                            state_next   = ST_DELIVER;
                        end else begin
                            exp_sel_next = exp_sel_reg - 3'd1;
                        end
                    end else begin
                        seq_err_next = 1'b1;
                        slot_clr     = 1'b1;
                        state_next   = ST_SYNC;
                    end
                end
            end
            ST_DELIVER: begin
                exp_sel_next = TOP_SEL;
                state_next   = ST_SCAN;
            end
            default: state_next = ST_SYNC;
        endcase
    end

    always_comb begin
        slot_digits_next = slot_digits_reg;
        slot_dps_next    = slot_dps_reg;
        slot_inv_next    = slot_inv_reg;
        if (slot_clr) begin
            slot_digits_next = '0;
            slot_dps_next    = '0;
            slot_inv_next    = '0;
        end else if (slot_we) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (s_sel == 3'(k)) begin
                    slot_digits_next[4*k +: 4] = dec_code;
                    slot_dps_next[k]           = s_dp;
                    slot_inv_next[k]           = dec_invalid;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg       <= '0;
            sync2_reg       <= '0;
            prev_reg        <= '0;
            cnt_reg         <= '0;
            last_sel_reg    <= '0;
            last_valid_reg  <= 1'b0;
            state_reg       <= ST_SYNC;
            exp_sel_reg     <= '0;
            slot_digits_reg <= '0;
            slot_dps_reg    <= '0;
            slot_inv_reg    <= '0;
            digits_out      <= '0;
            dps_out         <= '0;
            frame_err       <= 1'b0;
            frame_valid     <= 1'b0;
            seq_err         <= 1'b0;
        end else begin
            sync1_reg       <= {seg7_sel, seg7_out, dpt_out};
            sync2_reg       <= sync1_reg;
            prev_reg        <= sync2_reg;
            cnt_reg         <= cnt_next;
            if (cap_event) begin
                last_sel_reg   <= s_sel;
                last_valid_reg <= 1'b1;
            end
            state_reg       <= state_next;
            exp_sel_reg     <= exp_sel_next;
            slot_digits_reg <= slot_digits_next;
            slot_dps_reg    <= slot_dps_next;
            slot_inv_reg    <= slot_inv_next;
            // Outputs load on entry to DELIVER so they are valid with the pulse.
            if (deliver_load) begin
                digits_out <= slot_digits_next;
                dps_out    <= slot_dps_next;
                frame_err  <= |slot_inv_next;
            end
            frame_valid     <= deliver_load;
            seq_err         <= seq_err_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected frames / sequence errors, a
// monitor pops and compares whenever the decoder pulses an output.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  seg7_sel;
    logic [6:0]  seg7_out;
    logic        dpt_out;
    logic [23:0] digits_out;
    logic [5:0]  dps_out;
    logic        frame_valid;
    logic        frame_err;
    logic        seq_err;

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  dp;
        logic        err;
    } frame_t;

    frame_t exp_q[$];
    bit     seq_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   seq_prev = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(4), .NUM_DIGITS(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg7_sel    (seg7_sel),
        .seg7_out    (seg7_out),
        .dpt_out     (dpt_out),
        .digits_out  (digits_out),
        .dps_out     (dps_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .seq_err     (seq_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: pat = 7'h7E;
            4'd1: pat = 7'h30;
            4'd2: pat = 7'h6D;
            4'd3: pat = 7'h79;
            4'd4: pat = 7'h33;
            4'd5: pat = 7'h5B;
            4'd6: pat = 7'h5F;
            4'd7: pat = 7'h70;
            4'd8: pat = 7'h7F;
            4'd9: pat = 7'h7B;
            default: pat = 7'h00;
        endcase
    endfunction

    function automatic logic [41:0] pats6(input logic [23:0] h);
        logic [41:0] r;
        for (int k = 0; k < 6; k++) r[7*k +: 7] = pat(h[4*k +: 4]);
        return r;
    endfunction

    task automatic drive(input logic [2:0] s, input logic [6:0] p, input logic d, input int n);
        seg7_sel = s;
        seg7_out = p;
        dpt_out  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [41:0] p, input logic [5:0] d);
        for (int k = 5; k >= 0; k--) drive(3'(k), p[7*k +: 7], d[k], 8);
    endtask

    task automatic push_frame(input logic [23:0] dig, input logic [5:0] dp, input logic err);
        frame_t f;
        f.dig = dig;
        f.dp  = dp;
        f.err = err;
        exp_q.push_back(f);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digits"}, 32'(digits_out), 32'h0);
        chk({tag, "_dps"}, 32'(dps_out), 32'h0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'h0);
    endtask

    // Monitor: compares on every frame_valid / seq_err pulse.
    always @(negedge clk) begin
        frame_t f;
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'(digits_out), 32'hFFFF_FFFF);
            end else begin
                f = exp_q.pop_front();
                $display("frame digits=%h dps=%b err=%b", digits_out, dps_out, frame_err);
                chk("frame_digits", 32'(digits_out), 32'(f.dig));
                chk("frame_dps", 32'(dps_out), 32'(f.dp));
                chk("frame_err", 32'(frame_err), 32'(f.err));
            end
        end
        if (seq_err) begin
            $display("seq_err pulse");
            chk("seq_err_expected", 32'(seq_q.size() != 0), 32'd1);
            if (seq_q.size() != 0) void'(seq_q.pop_front());
            chk("seq_err_width", 32'(seq_prev), 32'd0);
        end
        seq_prev = seq_err;
    end

    initial begin
        logic [41:0] p;
        reset    = 1'b0;
        seg7_sel = 3'd0;
        seg7_out = 7'h00;
        dpt_out  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        // Stray sel=2 before any scan start is ignored; one frame after sel=0.
        drive(3'd2, pat(4'd5), 1'b0, 8);
        push_frame(24'h987654, 6'b000000, 1'b0);
        scan(pats6(24'h987654), 6'b000000);
        repeat (4) @(negedge clk);

        // Basic frame with decimal points, then outputs hold.
        push_frame(24'h111873, 6'b100101, 1'b0);
        scan(pats6(24'h111873), 6'b100101);
        repeat (10) @(negedge clk);
        chk("hold_digits", 32'(digits_out), 32'h111873);
        chk("hold_dps", 32'(dps_out), 32'b100101);
        chk("hold_err", 32'(frame_err), 32'h0);

        // Short 7F glitch inside the sel=3 hold must not disturb the frame.
        push_frame(24'h201945, 6'b000000, 1'b0);
        p = pats6(24'h201945);
        drive(3'd5, p[41:35], 1'b0, 8);
        drive(3'd4, p[34:28], 1'b0, 8);
        drive(3'd3, 7'h30, 1'b0, 8);
        drive(3'd3, 7'h7F, 1'b0, 2);
        drive(3'd3, 7'h30, 1'b0, 8);
        drive(3'd2, p[20:14], 1'b0, 8);
        drive(3'd1, p[13:7], 1'b0, 8);
        drive(3'd0, p[6:0], 1'b0, 8);
        repeat (4) @(negedge clk);

        // Broken scan 5,4,2 then a clean scan.
        seq_q.push_back(1'b1);
        drive(3'd5, pat(4'd1), 1'b0, 8);
        drive(3'd4, pat(4'd2), 1'b0, 8);
        drive(3'd2, pat(4'd3), 1'b0, 8);
        push_frame(24'h314159, 6'b111111, 1'b0);
        scan(pats6(24'h314159), 6'b111111);
        repeat (4) @(negedge clk);

        // Invalid pattern at sel=3, blank at sel=5.
        p = pats6(24'h024456);
        p[41:35] = 7'h00;
        p[27:21] = 7'h55;
        push_frame(24'hE2F456, 6'b000000, 1'b1);
        scan(p, 6'b000000);
        repeat (4) @(negedge clk);

        // Reset mid-scan: outputs clear immediately, partial tail gives no frame.
        p = pats6(24'h987654);
        drive(3'd5, p[41:35], 1'b0, 8);
        drive(3'd4, p[34:28], 1'b0, 8);
        drive(3'd3, p[27:21], 1'b0, 8);
        drive(3'd2, p[20:14], 1'b0, 8);
        reset = 1'b0;
        #1;
        check_zero("reset_mid");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive(3'd1, p[13:7], 1'b0, 8);
        drive(3'd0, p[6:0], 1'b0, 8);
        push_frame(24'h012345, 6'b010101, 1'b0);
        scan(pats6(24'h012345), 6'b010101);

        repeat (20) @(negedge clk);
        chk("frames_outstanding", 32'(exp_q.size()), 32'd0);
        chk("seq_err_outstanding", 32'(seq_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
